// File: rtl/mips_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_debug_pkg
//  Description : Shared constants for the MIPS pipeline debug controller.
//                Holds the command bytes, the bytes-per-word constant and the
//                state encodings of the controller FSM and of the PC-report
//                serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_debug_pkg;

  // UART command bytes
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'

  // Program words and PC reports travel as 4 bytes, MSB first
  localparam int BYTES_PER_WORD = 4;

  // Controller FSM encoding
  localparam int NB_STATE = 3;
  localparam logic [NB_STATE-1:0] ST_IDLE       = 3'd0;
  localparam logic [NB_STATE-1:0] ST_LOAD_CNT   = 3'd1;
  localparam logic [NB_STATE-1:0] ST_LOAD_BYTE  = 3'd2;
  localparam logic [NB_STATE-1:0] ST_LOAD_WRITE = 3'd3;
  localparam logic [NB_STATE-1:0] ST_RUN        = 3'd4;
  localparam logic [NB_STATE-1:0] ST_STEP       = 3'd5;
  localparam logic [NB_STATE-1:0] ST_STEP_CAP   = 3'd6;
  localparam logic [NB_STATE-1:0] ST_SEND       = 3'd7;

  // Serializer FSM encoding
  localparam int NB_SER_STATE = 2;
  localparam logic [NB_SER_STATE-1:0] SER_IDLE = 2'd0;
  localparam logic [NB_SER_STATE-1:0] SER_SEND = 2'd1;
  localparam logic [NB_SER_STATE-1:0] SER_WAIT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/debug_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_word_serializer
//  Description : Captures a word on i_load and sends it over the UART
//                transmitter one byte at a time, MSB first, using the
//                start/busy handshake. o_done pulses in the cycle the last
//                byte has finished transmitting.
//  Ports       : i_clk, i_rst        - clock, synchronous active-high reset
//                i_load, i_word      - capture strobe and word to send
//                i_tx_busy           - transmitter busy
//                o_tx_data           - byte presented to the transmitter
//                o_tx_start          - one-cycle transmit request
//                o_done              - one-cycle completion strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_word_serializer
  import mips_debug_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NB_WORD-1:0] i_word,
  input  logic               i_tx_busy,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_done
);

  logic [NB_SER_STATE-1:0] r_state;
  logic [NB_SER_STATE-1:0] w_state_next;
  logic [NB_WORD-1:0]      r_word;
  logic [1:0]              r_idx;
  logic                    r_first;
  logic                    w_start;
  logic                    w_done;

  // State register and datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SER_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == SER_IDLE && i_load) begin
        r_word <= i_word;
        r_idx  <= '0;
      end
      if (w_start) begin
        // Next byte moves into the top lane; the index wraps back to 0
        // once the final byte has been started.
        r_word  <= {r_word[NB_WORD-NB_DATA-1:0], {NB_DATA{1'b0}}};
        r_idx   <= r_idx + 2'd1;
        r_first <= 1'b1;
      end else if (r_state == SER_WAIT) begin
        r_first <= 1'b0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SER_IDLE: if (i_load) w_state_next = SER_SEND;
      SER_SEND: if (!i_tx_busy) w_state_next = SER_WAIT;
      // The first wait cycle is skipped: busy only rises one cycle after start
      SER_WAIT: if (!r_first && !i_tx_busy)
                  w_state_next = (r_idx == '0) ? SER_IDLE : SER_SEND;
      default:  w_state_next = SER_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_start = (r_state == SER_SEND) && !i_tx_busy;
    w_done  = (r_state == SER_WAIT) && !r_first && !i_tx_busy && (r_idx == '0);
  end

  assign o_tx_data  = r_word[NB_WORD-1 -: NB_DATA];
  assign o_tx_start = w_start;
  assign o_done     = w_done;

endmodule
`default_nettype wire

// File: rtl/pipeline_debug_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_debug_controller
//  Description : Byte-command sequencer between the UART and the MIPS
//                pipeline. 'L' loads program words into instruction memory,
//                'R' free-runs until halt, 'S' executes a single cycle. After
//                a run or step the fetch PC is reported over the UART.
//  Ports       : i_clk, i_rst              - clock, sync active-high reset
//                i_rx_data, i_rx_valid     - received byte and strobe
//                i_tx_busy                 - transmitter busy
//                i_halt, i_pc_count        - pipeline halt level, fetch PC
//                o_tx_data, o_tx_start     - transmit byte and request
//                o_pipe_enabled, o_pipe_rst- pipeline enable, soft reset
//                o_instr_write_enb, o_instr_addr, o_instr_data
//                                          - instruction-memory write port
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_debug_controller
  import mips_debug_pkg::*;
#(
  parameter int NB_DATA  = 8,
  parameter int NB_PC    = 32,
  parameter int NB_INSTR = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NB_DATA-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_tx_busy,
  input  logic                i_halt,
  input  logic [NB_PC-1:0]    i_pc_count,
  output logic [NB_DATA-1:0]  o_tx_data,
  output logic                o_tx_start,
  output logic                o_pipe_enabled,
  output logic                o_pipe_rst,
  output logic                o_instr_write_enb,
  output logic [NB_PC-1:0]    o_instr_addr,
  output logic [NB_INSTR-1:0] o_instr_data
);

  logic [NB_STATE-1:0] r_state;
  logic [NB_STATE-1:0] w_state_next;
  logic                r_pipe_enabled;
  logic                w_pipe_enabled_next;
  logic                r_pipe_rst;
  logic [8:0]          r_word_cnt;      // 1..256 words remaining
  logic [1:0]          r_byte_idx;
  logic [NB_PC-1:0]    r_instr_addr;
  logic [NB_INSTR-1:0] r_instr_data;
  logic                w_write;
  logic                w_last_word;
  logic                w_report_load;
  logic                w_ser_done;
  logic [8:0]          w_cnt_init;

  assign w_last_word = (r_word_cnt == 9'd1);
  // A count byte of zero stands for a full 256-word program
  assign w_cnt_init  = (i_rx_data == '0) ? 9'd256 : {1'b0, i_rx_data};

  // State register plus the registered pipeline controls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pipe_enabled <= 1'b0;
      r_pipe_rst     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pipe_enabled <= w_pipe_enabled_next;
      r_pipe_rst     <= w_write && w_last_word;
    end
  end

  // Load datapath: word counter, byte index, address and assembled word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word_cnt   <= '0;
      r_byte_idx   <= '0;
      r_instr_addr <= '0;
      r_instr_data <= '0;
    end else begin
      if (r_state == ST_LOAD_CNT && i_rx_valid) begin
        r_word_cnt   <= w_cnt_init;
        r_byte_idx   <= '0;
        r_instr_addr <= '0;
      end
      if (r_state == ST_LOAD_BYTE && i_rx_valid) begin
        r_instr_data <= {r_instr_data[NB_INSTR-NB_DATA-1:0], i_rx_data};
        r_byte_idx   <= r_byte_idx + 2'd1;
      end
      if (w_write) begin
        r_instr_addr <= r_instr_addr + 1'b1;
        r_word_cnt   <= r_word_cnt - 9'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: w_state_next = ST_LOAD_CNT;
            CMD_RUN:  w_state_next = ST_RUN;
            CMD_STEP: w_state_next = ST_STEP;
            default:  w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT:   if (i_rx_valid) w_state_next = ST_LOAD_BYTE;
      ST_LOAD_BYTE:  if (i_rx_valid && r_byte_idx == 2'(BYTES_PER_WORD - 1))
                       w_state_next = ST_LOAD_WRITE;
      ST_LOAD_WRITE: w_state_next = w_last_word ? ST_IDLE : ST_LOAD_BYTE;
      // Halt only counts once the pipeline is actually enabled, so a halt
      // already present on entry still yields one enabled cycle.
      ST_RUN:        if (r_pipe_enabled && i_halt) w_state_next = ST_SEND;
      ST_STEP:       if (r_pipe_enabled) w_state_next = ST_STEP_CAP;
      ST_STEP_CAP:   w_state_next = ST_SEND;
      ST_SEND:       if (w_ser_done) w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_pipe_enabled_next = 1'b0;
    w_write             = 1'b0;
    w_report_load       = 1'b0;
    case (r_state)
      ST_LOAD_WRITE: w_write = 1'b1;
      ST_RUN: begin
        w_pipe_enabled_next = !(r_pipe_enabled && i_halt);
        w_report_load       = r_pipe_enabled && i_halt;
      end
      ST_STEP:       w_pipe_enabled_next = !r_pipe_enabled;
      ST_STEP_CAP:   w_report_load = 1'b1;
      default: ;
    endcase
  end

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_WORD (NB_PC)
  ) u_pc_report (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_report_load),
    .i_word     (i_pc_count),
    .i_tx_busy  (i_tx_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_done     (w_ser_done)
  );

  assign o_pipe_enabled    = r_pipe_enabled;
  assign o_pipe_rst        = r_pipe_rst;
  assign o_instr_write_enb = w_write;
  assign o_instr_addr      = r_instr_addr;
  assign o_instr_data      = r_instr_data;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_debug_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_debug_controller
//  Description : Self-checking bench for pipeline_debug_controller. A
//                negedge monitor records writes, soft resets, enabled cycles
//                and transmitted bytes; expectations come from the command
//                protocol (word lists, PC bytes, enabled-cycle counts).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_debug_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic        halt;
  logic [31:0] pc_count;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        pipe_enabled;
  logic        pipe_rst;
  logic        instr_write_enb;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          rst_cyc_q[$];
  logic [7:0]  tx_q[$];
  int          en_cycles = 0;
  bit          overlap   = 1'b0;
  bit          bad_start = 1'b0;

  pipeline_debug_controller dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .i_tx_busy         (tx_busy),
    .i_halt            (halt),
    .i_pc_count        (pc_count),
    .o_tx_data         (tx_data),
    .o_tx_start        (tx_start),
    .o_pipe_enabled    (pipe_enabled),
    .o_pipe_rst        (pipe_rst),
    .o_instr_write_enb (instr_write_enb),
    .o_instr_addr      (instr_addr),
    .o_instr_data      (instr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (instr_write_enb) begin
      wr_addr_q.push_back(instr_addr);
      wr_data_q.push_back(instr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (pipe_rst) rst_cyc_q.push_back(cyc);
    if (pipe_enabled) en_cycles = en_cycles + 1;
    if (pipe_enabled && instr_write_enb) overlap = 1'b1;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      if (tx_busy) bad_start = 1'b1;
    end
  end

  // Transmitter model: busy rises the cycle after start, lasts 1..6 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    tick($urandom_range(2, 4));
  endtask

  task automatic load_words(input logic [31:0] w[$]);
    int n;
    int wb;
    int rb;
    logic [31:0] word;
    n  = w.size();
    wb = wr_addr_q.size();
    rb = rst_cyc_q.size();
    send_byte(8'h4C);
    send_byte(8'(n % 256));
    for (int i = 0; i < n; i++) begin
      word = w[i];
      for (int j = 3; j >= 0; j--) send_byte(word[8*j +: 8]);
    end
    tick(3);
    check("load_write_count", 32'(wr_addr_q.size() - wb), 32'(n));
    if (wr_addr_q.size() - wb == n) begin
      for (int i = 0; i < n; i++) begin
        check("load_addr", wr_addr_q[wb+i], 32'(i));
        check("load_data", wr_data_q[wb+i], w[i]);
      end
    end
    check("load_rst_count", 32'(rst_cyc_q.size() - rb), 32'd1);
    if (rst_cyc_q.size() > rb && wr_cyc_q.size() > wb)
      check("load_rst_timing", 32'(rst_cyc_q[rb]), 32'(wr_cyc_q[wr_cyc_q.size()-1] + 1));
  endtask

  task automatic expect_report(input logic [31:0] pc, input int tb);
    int g;
    logic [31:0] pcv;
    g   = 0;
    pcv = pc;
    while (tx_q.size() < tb + 4 && g < 600) begin
      tick(1);
      g++;
    end
    check("report_timeout", 32'(tx_q.size() >= tb + 4), 32'd1);
    if (tx_q.size() >= tb + 4)
      for (int i = 0; i < 4; i++)
        check("report_byte", 32'(tx_q[tb+i]), 32'(pcv[8*(3-i) +: 8]));
    tick(12);
    check("report_len", 32'(tx_q.size() - tb), 32'd4);
  endtask

  task automatic do_step(input logic [31:0] pc);
    int eb;
    int tb;
    pc_count = pc;
    eb = en_cycles;
    tb = tx_q.size();
    send_byte(8'h53);
    expect_report(pc, tb);
    check("step_en_cycles", 32'(en_cycles - eb), 32'd1);
  endtask

  task automatic do_run(input logic [31:0] pc, input int k);
    int eb;
    int tb;
    int g;
    pc_count = pc;
    halt     = 1'b0;
    eb = en_cycles;
    tb = tx_q.size();
    g  = 0;
    send_byte(8'h52);
    while (en_cycles - eb < k && g < 200) begin
      tick(1);
      g++;
    end
    check("run_en_before_halt", 32'(pipe_enabled), 32'd1);
    halt = 1'b1;
    tick(1);
    check("run_en_drop", 32'(pipe_enabled), 32'd0);
    expect_report(pc, tb);
    halt = 1'b0;
    check("run_en_cycles", 32'(en_cycles - eb), 32'(k + 1));
  endtask

  logic [31:0] words[$];
  int          wb0;
  int          eb0;
  int          tb0;

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    halt     = 1'b0;
    pc_count = 32'h0;
    tick(3);
    check("reset_ctrl", 32'({tx_start, pipe_enabled, pipe_rst, instr_write_enb}), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_addr", instr_addr, 32'd0);
    check("reset_data", instr_data, 32'd0);
    rst = 1'b0;
    tick(2);

    // Non-command byte in IDLE does nothing
    eb0 = en_cycles;
    tb0 = tx_q.size();
    send_byte(8'h41);
    tick(5);
    check("ignored_byte_en", 32'(en_cycles - eb0), 32'd0);
    check("ignored_byte_tx", 32'(tx_q.size() - tb0), 32'd0);

    // Reset after two data bytes of a load
    wb0 = wr_addr_q.size();
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b1;
    tick(1);
    check("midload_rst_ctrl", 32'({tx_start, pipe_enabled, pipe_rst, instr_write_enb}), 32'd0);
    check("midload_rst_addr", instr_addr, 32'd0);
    check("midload_rst_data", instr_data, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    do_run($urandom, 6);
    check("midload_no_stray_write", 32'(wr_addr_q.size() - wb0), 32'd0);

    // Single word
    words.delete();
    words.push_back(32'hDEADBEEF);
    load_words(words);

    // Two words, the first one beginning with the 'R' byte
    words.delete();
    words.push_back({8'h52, 24'($urandom)});
    words.push_back($urandom);
    load_words(words);

    // Step and run directed cases
    do_step(32'h00000005);
    do_run(32'h0000000A, 10);

    // Halt already high: one enabled cycle; bytes during SEND are dropped
    halt     = 1'b1;
    pc_count = 32'h1234ABCD;
    eb0 = en_cycles;
    tb0 = tx_q.size();
    wb0 = wr_addr_q.size();
    send_byte(8'h52);
    send_byte(8'h4C);
    send_byte(8'h01);
    expect_report(32'h1234ABCD, tb0);
    check("halt_early_en_cycles", 32'(en_cycles - eb0), 32'd1);
    halt = 1'b0;
    do_step(32'hCAFE0042);
    check("send_bytes_ignored", 32'(wr_addr_q.size() - wb0), 32'd0);

    // Randomized loads, steps and runs
    for (int r = 0; r < 3; r++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back($urandom);
      load_words(words);
      if ($urandom_range(0, 1) == 1) do_step($urandom);
      else do_run($urandom, int'($urandom_range(6, 15)));
    end

    // Count byte 0 loads 256 words; addresses end at 255
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back($urandom);
    load_words(words);

    check("no_enable_write_overlap", 32'(overlap), 32'd0);
    check("tx_start_only_when_idle", 32'(bad_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
